// File: rtl/ctrl_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_multiciclo
// Description : Multi-cycle control FSM for the 26-bit core. Sequences
//               instruction fetch, decode, ALU execute, data memory access,
//               register writeback and PC update. Also hosts a memory-wait
//               watchdog and a retired-instruction counter.
// Ports       : clk, rst_n          clock, async active-low reset
//               start_i             leave IDLE/HALTED and begin fetching
//               opcode_i[5:0]       decoded opcode (valid from EXEC onward)
//               flag_z_i, flag_n_i  ALU compare flags
//               imem_req_o / imem_ready_i         instruction fetch handshake
//               dmem_req_o, dmem_we_o / dmem_ready_i  data access handshake
//               ir_we_o, dec_en_o, alu_src_imm_o, alu_op_o, reg_we_o,
//               wb_sel_mem_o, pc_we_o, pc_src_o   datapath controls
//               busy_o, halted_o, err_o, retired_cnt_o  status
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_multiciclo #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [5:0]       opcode_i,
  input  logic             flag_z_i,
  input  logic             flag_n_i,
  output logic             imem_req_o,
  input  logic             imem_ready_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  input  logic             dmem_ready_i,
  output logic             ir_we_o,
  output logic             dec_en_o,
  output logic             alu_src_imm_o,
  output logic [2:0]       alu_op_o,
  output logic             reg_we_o,
  output logic             wb_sel_mem_o,
  output logic             pc_we_o,
  output logic [1:0]       pc_src_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic             err_o,
  output logic [CNT_W-1:0] retired_cnt_o
);

  localparam int              WAIT_W      = $clog2(WAIT_MAX + 1);
  // Value of the wait counter during the last permitted not-ready cycle.
  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
  localparam logic [5:0]      C_OP_HALT   = 6'b111111;
  localparam logic [1:0]      C_CLS_MEM   = 2'b10;
  localparam logic [1:0]      C_CLS_BR    = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEM    = 4'd4,
    S_WB     = 4'd5,
    S_BR     = 4'd6,
    S_HALTED = 4'd7,
    S_ERROR  = 4'd8
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q,  wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire;
  logic               br_taken;
  logic [1:0]         op_cls;

  assign op_cls = opcode_i[5:4];

  // Compare-branch condition selected by subop; subops 1xx never branch.
  always_comb begin
    br_taken = 1'b0;
    case (opcode_i[2:0])
      3'b000:  br_taken =  flag_z_i;
      3'b001:  br_taken = ~flag_z_i;
      3'b010:  br_taken =  flag_n_i;
      3'b011:  br_taken = ~flag_n_i;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    imem_req_o    = 1'b0;
    dmem_req_o    = 1'b0;
    dmem_we_o     = 1'b0;
    ir_we_o       = 1'b0;
    dec_en_o      = 1'b0;
    alu_src_imm_o = 1'b0;
    alu_op_o      = 3'b000;
    reg_we_o      = 1'b0;
    wb_sel_mem_o  = 1'b0;
    pc_we_o       = 1'b0;
    pc_src_o      = 2'b00;
    halted_o      = 1'b0;
    err_o         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ready_i) begin
          // PC+1 is written in the same cycle the word is captured.
          ir_we_o  = 1'b1;
          pc_we_o  = 1'b1;
          pc_src_o = 2'b00;
          state_d  = S_DECODE;
        end else if (wait_q == C_WAIT_LAST) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        dec_en_o = 1'b1;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        alu_src_imm_o = (op_cls != C_CLS_BR) & opcode_i[3];
        if (opcode_i == C_OP_HALT) begin
          retire  = 1'b1;
          state_d = S_HALTED;
        end else begin
          case (op_cls)
            2'b00, 2'b01: begin
              alu_op_o = opcode_i[2:0];
              state_d  = S_WB;
            end
            C_CLS_MEM: begin
              alu_op_o = 3'b000;  // address = rn + imm10
              state_d  = S_MEM;
            end
            default: begin
              alu_op_o = opcode_i[3] ? 3'b000 : 3'b001;
              state_d  = S_BR;
            end
          endcase
        end
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = opcode_i[0];
        if (dmem_ready_i) begin
          if (opcode_i[0]) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == C_WAIT_LAST) begin
          state_d = S_ERROR;
        end
      end
      S_WB: begin
        reg_we_o     = 1'b1;
        wb_sel_mem_o = (op_cls == C_CLS_MEM);
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_BR: begin
        if (opcode_i[3]) begin
          pc_we_o  = 1'b1;
          pc_src_o = 2'b10;
        end else if (br_taken) begin
          pc_we_o  = 1'b1;
          pc_src_o = 2'b01;
        end
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALTED: begin
        halted_o = 1'b1;
        if (start_i) state_d = S_FETCH;
      end
      S_ERROR: begin
        err_o = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The wait counter only survives while sitting in the same wait state with
  // ready low; any other cycle leaves it at zero, so every entry into FETCH or
  // MEM starts from a cleared count.
  always_comb begin
    wait_d = '0;
    if (((state_q == S_FETCH) && !imem_ready_i && (state_d == S_FETCH)) ||
        ((state_q == S_MEM)   && !dmem_ready_i && (state_d == S_MEM))) begin
      wait_d = wait_q + 1'b1;
    end
  end

  assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE) && (state_q != S_HALTED) &&
                         (state_q != S_ERROR);
  assign retired_cnt_o = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_multiciclo
// Description : Self-checking bench for ctrl_multiciclo. Each instruction is
//               expanded by a transaction-level reference into its expected
//               per-cycle control vector; a directed table plus randomized
//               instructions, HALT/resume, watchdog and async reset scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_multiciclo;

  localparam int CNT_W = 4;
  localparam int WMAX  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [5:0]       opcode;
  logic             flag_z, flag_n;
  logic             imem_req, imem_ready;
  logic             dmem_req, dmem_we, dmem_ready;
  logic             ir_we, dec_en, alu_src_imm;
  logic [2:0]       alu_op;
  logic             reg_we, wb_sel_mem, pc_we;
  logic [1:0]       pc_src;
  logic             busy, halted, err;
  logic [CNT_W-1:0] retired_cnt;

  ctrl_multiciclo #(.CNT_W(CNT_W), .WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .opcode_i(opcode),
    .flag_z_i(flag_z), .flag_n_i(flag_n),
    .imem_req_o(imem_req), .imem_ready_i(imem_ready),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_ready_i(dmem_ready),
    .ir_we_o(ir_we), .dec_en_o(dec_en), .alu_src_imm_o(alu_src_imm),
    .alu_op_o(alu_op), .reg_we_o(reg_we), .wb_sel_mem_o(wb_sel_mem),
    .pc_we_o(pc_we), .pc_src_o(pc_src), .busy_o(busy), .halted_o(halted),
    .err_o(err), .retired_cnt_o(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req, dmem_req, dmem_we, ir_we, dec_en, alu_src_imm;
    logic [2:0] alu_op;
    logic       reg_we, wb_sel_mem, pc_we;
    logic [1:0] pc_src;
    logic       busy, halted, err;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    int         iw, dw;
    logic       fz, fn;
    logic [2:0] x_aluop;
    logic       x_src, x_reg_we, x_wbm, x_pc_we;
    logic [1:0] x_pc_src;
  } vec_t;

  outs_t            dut_o, last_seen;
  logic [CNT_W-1:0] ret_model;
  int               checks = 0;
  int               errors = 0;
  bit               in_halt = 0;
  bit               in_err  = 0;

  assign dut_o = {imem_req, dmem_req, dmem_we, ir_we, dec_en, alu_src_imm,
                  alu_op, reg_we, wb_sel_mem, pc_we, pc_src, busy, halted, err};

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic check_now(input string nm, input outs_t e);
    last_seen = dut_o;
    checks++;
    if (dut_o !== e) begin
      errors++;
      $display("FAIL %s outs got %h want %h (t=%0t)", nm, dut_o, e, $time);
    end
    checks++;
    if (retired_cnt !== ret_model) begin
      errors++;
      $display("FAIL %s retired_cnt got %0d want %0d", nm, retired_cnt, ret_model);
    end
  endtask

  // Called at posedge+1: drive inputs, check at posedge+2, advance one cycle.
  task automatic cyc(input logic st, input logic ir, input logic dr,
                     input logic fz, input logic fn, input logic [5:0] op,
                     input outs_t e, input bit retire, input string nm);
    start = st; imem_ready = ir; dmem_ready = dr;
    flag_z = fz; flag_n = fn; opcode = op;
    #1;
    check_now(nm, e);
    @(posedge clk); #1;
    if (retire) ret_model = ret_model + 1'b1;
  endtask

  task automatic kick(input bit from_halt);
    outs_t e;
    e = '0;
    e.halted = from_halt;
    cyc(1'b1, rb(), rb(), rb(), rb(), 6'($urandom), e, 1'b0, "kick");
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    ret_model = '0;
    check_now(nm, '0);
    @(posedge clk); #1;
    check_now({nm, "_held"}, '0);
    rst_n = 1'b1;
    in_halt = 0; in_err = 0;
  endtask

  // Transaction-level reference: one instruction from FETCH to completion.
  task automatic run_instr(input logic [5:0] op, input int iw, input int dw,
                           input logic fz, input logic fn, input bit rst_in_mem,
                           output outs_t exec_o, output outs_t last_o);
    outs_t      e;
    logic [1:0] cls;
    logic       tk;
    cls = op[5:4];
    exec_o = '0; last_o = '0;
    for (int k = 0; k < iw && k < WMAX; k++) begin
      e = '0; e.imem_req = 1'b1; e.busy = 1'b1;
      cyc(rb(), 1'b0, rb(), rb(), rb(), 6'($urandom), e, 1'b0, "fetch_wait");
    end
    if (iw >= WMAX) begin in_err = 1; return; end
    e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1; e.busy = 1'b1;
    cyc(rb(), 1'b1, rb(), rb(), rb(), 6'($urandom), e, 1'b0, "fetch_acc");
    e = '0; e.dec_en = 1'b1; e.busy = 1'b1;
    cyc(rb(), rb(), rb(), rb(), rb(), op, e, 1'b0, "decode");
    e = '0; e.busy = 1'b1;
    if (cls != 2'b11) e.alu_src_imm = op[3];
    if (cls < 2'b10) e.alu_op = op[2:0];
    else if (cls == 2'b11 && !op[3]) e.alu_op = 3'b001;
    cyc(rb(), rb(), rb(), rb(), rb(), op, e, (op == 6'h3f), "exec");
    exec_o = last_seen; last_o = last_seen;
    if (op == 6'h3f) begin in_halt = 1; return; end
    if (cls == 2'b10) begin
      e = '0; e.dmem_req = 1'b1; e.dmem_we = op[0]; e.busy = 1'b1;
      for (int k = 0; k < dw && k < WMAX; k++)
        cyc(rb(), rb(), 1'b0, rb(), rb(), op, e, 1'b0, "mem_wait");
      if (rst_in_mem) begin do_reset("rst_mid_mem"); return; end
      if (dw >= WMAX) begin in_err = 1; return; end
      cyc(rb(), rb(), 1'b1, rb(), rb(), op, e, op[0], "mem_acc");
      last_o = last_seen;
      if (op[0]) return;
    end
    e = '0; e.busy = 1'b1;
    if (cls != 2'b11) begin
      e.reg_we = 1'b1; e.wb_sel_mem = (cls == 2'b10);
      cyc(rb(), rb(), rb(), rb(), rb(), op, e, 1'b1, "wb");
    end else begin
      if (op[3]) begin
        e.pc_we = 1'b1; e.pc_src = 2'b10;
      end else begin
        case (op[2:0])
          3'd0: tk = fz;
          3'd1: tk = !fz;
          3'd2: tk = fn;
          3'd3: tk = !fn;
          default: tk = 1'b0;
        endcase
        if (tk) begin e.pc_we = 1'b1; e.pc_src = 2'b01; end
      end
      cyc(rb(), rb(), rb(), fz, fn, op, e, 1'b1, "br");
    end
    last_o = last_seen;
  endtask

  task automatic err_cycles(input int n);
    outs_t e;
    e = '0; e.err = 1'b1;
    for (int k = 0; k < n; k++)
      cyc(1'b1, rb(), rb(), rb(), rb(), 6'($urandom), e, 1'b0, "error_sticky");
  endtask

  initial begin
    vec_t  tbl[12];
    outs_t ex, la, e;
    tbl[0]  = '{6'b000010, 0, 0, 0, 0, 3'b010, 0, 1, 0, 0, 2'b00};
    tbl[1]  = '{6'b001101, 1, 0, 0, 0, 3'b101, 1, 1, 0, 0, 2'b00};
    tbl[2]  = '{6'b011011, 0, 0, 1, 1, 3'b011, 1, 1, 0, 0, 2'b00};
    tbl[3]  = '{6'b100000, 3, 3, 0, 0, 3'b000, 0, 1, 1, 0, 2'b00};
    tbl[4]  = '{6'b101001, 0, 1, 0, 0, 3'b000, 1, 0, 0, 0, 2'b00};
    tbl[5]  = '{6'b110000, 0, 0, 1, 0, 3'b001, 0, 0, 0, 1, 2'b01};
    tbl[6]  = '{6'b110000, 2, 0, 0, 0, 3'b001, 0, 0, 0, 0, 2'b00};
    tbl[7]  = '{6'b111000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 2'b10};
    tbl[8]  = '{6'b110011, 0, 0, 1, 0, 3'b001, 0, 0, 0, 1, 2'b01};
    tbl[9]  = '{6'b110100, 0, 0, 1, 1, 3'b001, 0, 0, 0, 0, 2'b00};
    tbl[10] = '{6'b110010, 1, 0, 0, 1, 3'b001, 0, 0, 0, 1, 2'b01};
    tbl[11] = '{6'b110001, 0, 0, 1, 1, 3'b001, 0, 0, 0, 0, 2'b00};

    rst_n = 1'b0; start = 1'b0; opcode = '0; flag_z = 1'b0; flag_n = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; ret_model = '0;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset", '0);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++)
      cyc(1'b0, rb(), rb(), rb(), rb(), 6'($urandom), '0, 1'b0, "idle");
    kick(1'b0);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_instr(tbl[i].op, tbl[i].iw, tbl[i].dw, tbl[i].fz, tbl[i].fn, 1'b0, ex, la);
      chk($sformatf("tbl%0d_alu_op", i),   ex.alu_op,      tbl[i].x_aluop);
      chk($sformatf("tbl%0d_src_imm", i),  ex.alu_src_imm, tbl[i].x_src);
      chk($sformatf("tbl%0d_reg_we", i),   la.reg_we,      tbl[i].x_reg_we);
      chk($sformatf("tbl%0d_wb_mem", i),   la.wb_sel_mem,  tbl[i].x_wbm);
      chk($sformatf("tbl%0d_pc_we", i),    la.pc_we,       tbl[i].x_pc_we);
      chk($sformatf("tbl%0d_pc_src", i),   la.pc_src,      tbl[i].x_pc_src);
    end

    // Randomized instruction stream (counter wraps at 2^CNT_W)
    for (int i = 0; i < 150; i++) begin
      run_instr(6'($urandom), $urandom_range(WMAX-1, 0), $urandom_range(WMAX-1, 0),
                rb(), rb(), 1'b0, ex, la);
      if (in_halt) begin
        e = '0; e.halted = 1'b1;
        cyc(1'b0, rb(), rb(), rb(), rb(), 6'($urandom), e, 1'b0, "halted_wait");
        kick(1'b1);
        in_halt = 0;
      end
    end

    // HALT then resume
    run_instr(6'b111111, 1, 0, 0, 0, 1'b0, ex, la);
    e = '0; e.halted = 1'b1;
    for (int k = 0; k < 3; k++)
      cyc(1'b0, rb(), rb(), rb(), rb(), 6'($urandom), e, 1'b0, "halted");
    kick(1'b1);
    in_halt = 0;
    run_instr(6'b000010, 0, 0, 0, 0, 1'b0, ex, la);

    // Async reset in the middle of a load
    run_instr(6'b100000, 0, 2, 0, 0, 1'b1, ex, la);
    cyc(1'b0, rb(), rb(), rb(), rb(), 6'($urandom), '0, 1'b0, "idle_after_rst");
    kick(1'b0);
    run_instr(6'b000001, 0, 0, 0, 0, 1'b0, ex, la);

    // Fetch watchdog: WMAX not-ready cycles -> sticky ERROR, start ignored
    run_instr(6'b000000, WMAX, 0, 0, 0, 1'b0, ex, la);
    chk("fetch_wdog_model", int'(in_err), 1);
    err_cycles(5);
    do_reset("rst_from_err");
    cyc(1'b0, rb(), rb(), rb(), rb(), 6'($urandom), '0, 1'b0, "idle_after_err");

    // Data-memory watchdog on a store
    kick(1'b0);
    run_instr(6'b100001, 0, WMAX, 0, 0, 1'b0, ex, la);
    err_cycles(4);
    do_reset("rst_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
